sci_host: RTL and testbench
===========================

Name: sci_host

Overview:
- Bus initiator for the SCI register interface: the CPU-side end that drives scisel/rw/addr/dbus toward the UART peripheral.
- Configures SCCR after reset and whenever asked.
- Polls SCSR, drains RDR into a valid/ready receive stream, and feeds TDR from a valid/ready transmit stream.
- Lets a datapath or test harness use the UART without a processor.

Parameters:
POLL_GAP, 4, idle cycles between SCSR polls when the previous poll found nothing to do (range 1..255)

Ports:
clk  input  1  system clock, all activity on rising edge
rst  input  1  asynchronous, active-high reset
scisel  output  1  peripheral select, high during exactly one cycle per access
rw  output  1  1 = write access, 0 = read access
addr  output  2  register address: 00 RDR/TDR, 01 SCSR, 11 SCCR
dbus  inout  8  shared data bus; driven by this block only when scisel=1 and rw=1, otherwise Z
sciirq  input  1  peripheral interrupt request
tx_data  input  8  byte to transmit
tx_valid  input  1  tx_data valid; held with tx_data stable until accepted
tx_ready  output  1  high only in the cycle TDR is written; transfer occurs when tx_valid&tx_ready
rx_data  output  8  received byte
rx_valid  output  1  rx_data/rx_oe/rx_fe valid; held until rx_ready
rx_ready  input  1  consumer accepts the rx byte
rx_oe  output  1  overrun flag captured with rx_data
rx_fe  output  1  framing-error flag captured with rx_data
cfg_baudsel  input  2  baud select written to SCCR[1:0]
cfg_tie  input  1  written to SCCR[7]
cfg_rie  input  1  written to SCCR[6]
cfg_load  input  1  one-cycle pulse requesting an SCCR rewrite
busy  output  1  high while a configuration write is pending or in progress

Behaviour:
- Access model: each access is one cycle with scisel=1.
  - Write: dbus is driven by this block; the peripheral captures it at the closing edge.
  - Read: dbus is sampled at the closing edge.
  - Every access is followed by at least one TURN cycle: scisel=0, dbus=Z. No two consecutive cycles have scisel=1.
- States:
  - CFG: write addr 11, dbus={cfg_tie,cfg_rie,4'b0,cfg_baudsel}; clears cfg pending.
  - TURN: idle, one cycle.
  - GAP: idle, counts down.
  - POLL: read addr 01; capture scsr={tdre,rdrf,4'b0,oe,fe}.
  - RDR: read addr 00; capture the byte.
  - TDR: write addr 00 with dbus=tx_data; tx_ready=1.
- Reset (rst=1, immediate, mid-access included):
  - Outputs: scisel=0, rw=0, addr=00, dbus=Z, tx_ready=0, rx_valid=0, rx_data=0, rx_oe=0, rx_fe=0.
  - cfg pending=1, busy=1, state=CFG.
  - First access after reset release is the CFG write, issued on the first clock edge.
- Transitions:
  - CFG -> TURN.
  - TURN -> CFG if cfg pending, else -> POLL.
  - POLL -> TURN, with the next access selected by priority:
    1. cfg pending -> CFG.
    2. Captured rdrf=1 and rx_valid=0 -> RDR.
    3. Captured tdre=1 and tx_valid=1 -> TDR.
    4. Otherwise -> GAP with counter=POLL_GAP.
  - RDR -> TURN -> POLL.
  - TDR -> TURN -> POLL.
  - GAP decrements each cycle. It exits to TURN-equivalent selection (CFG if pending, else POLL) when:
    - counter reaches 0, or
    - sciirq=1, or
    - tx_valid=1, or
    - cfg pending.
  - GAP exits take effect on the following cycle. GAP itself is an idle cycle and satisfies the turnaround rule.
- Receive capture:
  - At the RDR edge: rx_data<=dbus, rx_oe<=oe and rx_fe<=fe (from the preceding POLL), rx_valid<=1.
  - rx_valid clears on the edge where rx_valid&rx_ready.
  - While rx_valid=1 with no rx_ready, RDR is never read. The peripheral keeps rdrf and may raise oe; that oe is reported with the next byte.
- Transmit:
  - TDR is written only when the most recent POLL showed tdre=1, so the peripheral never sees loadtdr with tdre=0.
  - tx_valid dropping between POLL and TDR is a protocol violation; behaviour is unspecified.
- cfg_load:
  - Sets cfg pending, sampled any cycle including mid-access; busy=1 from the next cycle.
  - Serviced at the next access slot, ahead of RX/TX.
  - cfg_* inputs are sampled in the CFG cycle itself.
  - busy falls the cycle after the CFG write.
  - cfg_load in the CFG cycle itself sets pending again, causing a second write.
- Latency from idle GAP:
  - tx_valid rise -> TURN -> POLL -> TURN -> TDR: TDR write 4 cycles later.
  - rdrf with sciirq -> same path: RDR read 4 cycles after sciirq.

Test Plan:
- Reset release, cfg_baudsel=2'b10, cfg_tie=0, cfg_rie=1 -> first cycle scisel=1, rw=1, addr=11, dbus=8'h42; busy drops next cycle; then POLL read of addr 01 after one idle cycle.
- Peripheral model with tdre=1, tx_valid with tx_data=8'hA5 -> exactly one write to addr 00 with dbus=8'hA5, tx_ready high that cycle only; no TDR write while the model reports tdre=0.
- Model sets rdrf=1, fe=1, RDR=8'h3C, rx_ready=1 -> one read of addr 00; rx_valid with rx_data=8'h3C, rx_fe=1, rx_oe=0 for one cycle.
- rx_ready held 0 with two bytes arriving -> only one RDR read; rx_valid stays high with the first byte; after rx_ready the second RDR read occurs and rx_oe reflects the model's oe=1.
- Both tdre=1 with tx_valid and rdrf=1 at one POLL -> RDR read precedes TDR write; scisel never high on two consecutive cycles.
- cfg_load pulse during a TDR cycle with cfg_baudsel=2'b01 -> next access is an SCCR write of 8'h01 before any further POLL; rst asserted mid-RDR -> scisel=0, dbus=Z, rx_valid=0 immediately.

Source files
------------

// File: rtl/sci_host.sv
// SCI register-bus initiator: configures SCCR, polls SCSR, drains RDR into an rx
// stream and feeds TDR from a tx stream. One access cycle, always followed by an idle cycle.
module sci_host #(
  parameter int POLL_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       scisel,
  output logic       rw,
  output logic [1:0] addr,
  inout  wire  [7:0] dbus,
  input  logic       sciirq,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_oe,
  output logic       rx_fe,
  input  logic [1:0] cfg_baudsel,
  input  logic       cfg_tie,
  input  logic       cfg_rie,
  input  logic       cfg_load,
  output logic       busy
);

  typedef enum logic [2:0] {S_CFG, S_TURN, S_GAP, S_POLL, S_RDR, S_TDR} state_t;

  state_t     state, state_nx, tgt, tgt_nx;
  logic       run, pend;
  logic [7:0] cnt, cnt_nx, dout;
  logic       oe_q, fe_q;

  // run is low only until the first edge after reset, so the bus stays idle in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      pend  <= 1'b1;
      state <= S_CFG;
      tgt   <= S_POLL;
      cnt   <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      tgt   <= tgt_nx;
      cnt   <= cnt_nx;
      if (cfg_load)                   pend <= 1'b1;
      else if (run && state == S_CFG) pend <= 1'b0;
    end
  end

  assign busy = pend;

  // Bus drive decode
  always_comb begin
    scisel   = 1'b0;
    rw       = 1'b0;
    addr     = 2'b00;
    dout     = 8'h00;
    tx_ready = 1'b0;
    if (run) begin
      case (state)
        S_CFG:  begin scisel = 1'b1; rw = 1'b1; addr = 2'b11;
                      dout = {cfg_tie, cfg_rie, 4'b0000, cfg_baudsel}; end
        S_POLL: begin scisel = 1'b1; addr = 2'b01; end
        S_RDR:  begin scisel = 1'b1; addr = 2'b00; end
        S_TDR:  begin scisel = 1'b1; rw = 1'b1; addr = 2'b00;
                      dout = tx_data; tx_ready = 1'b1; end
        default: ;
      endcase
    end
  end

  assign dbus = (scisel && rw) ? dout : 8'hzz;

  // Next access selection; tgt remembers what the last POLL decided
  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    cnt_nx   = cnt;
    if (run) begin
      case (state)
        S_CFG:  begin state_nx = S_TURN; tgt_nx = S_POLL; end
        S_TURN: state_nx = pend ? S_CFG : tgt;
        S_POLL: begin
          state_nx = S_TURN;
          if (dbus[6] && !rx_valid)     tgt_nx = S_RDR;
          else if (dbus[7] && tx_valid) tgt_nx = S_TDR;
          else begin
            tgt_nx = S_POLL;
            if (!pend) begin
              state_nx = S_GAP;
              cnt_nx   = 8'(POLL_GAP);
            end
          end
        end
        S_GAP: begin
          cnt_nx = cnt - 8'd1;
          if (cnt_nx == 8'd0 || sciirq || tx_valid || pend) state_nx = S_TURN;
        end
        S_RDR, S_TDR: begin state_nx = S_TURN; tgt_nx = S_POLL; end
        default: state_nx = S_CFG;
      endcase
    end
  end

  // Status flags from the POLL travel with the byte read right after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q     <= 1'b0;
      fe_q     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_oe    <= 1'b0;
      rx_fe    <= 1'b0;
    end else begin
      if (run && state == S_POLL) begin
        oe_q <= dbus[1];
        fe_q <= dbus[0];
      end
      if (run && state == S_RDR) begin
        rx_data  <= dbus;
        rx_oe    <= oe_q;
        rx_fe    <= fe_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sci_host.sv
// Directed bench for sci_host with a small SCI peripheral model on the shared bus.
module tb_sci_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scisel, rw, tx_ready, rx_valid, rx_oe, rx_fe, busy;
  logic [1:0] addr;
  wire  [7:0] dbus;
  logic       sciirq;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic [1:0] cfg_baudsel = 2'b10;
  logic       cfg_tie = 1'b0, cfg_rie = 1'b1, cfg_load = 1'b0;

  sci_host #(.POLL_GAP(4)) dut (
    .clk(clk), .rst(rst), .scisel(scisel), .rw(rw), .addr(addr), .dbus(dbus),
    .sciirq(sciirq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_oe(rx_oe),
    .rx_fe(rx_fe), .cfg_baudsel(cfg_baudsel), .cfg_tie(cfg_tie), .cfg_rie(cfg_rie),
    .cfg_load(cfg_load), .busy(busy)
  );

  always #5 clk = ~clk;

  // Peripheral model: rx byte FIFO, status register, read-side bus drive
  logic       m_tdre = 1'b0, m_oe = 1'b0, m_fe = 1'b0;
  logic [7:0] rxq [0:7];
  int         npush = 0, nrd = 0;
  logic       m_rdrf;
  logic [7:0] m_stat, m_dat;

  assign m_rdrf = (npush > nrd);
  assign m_stat = {m_tdre, m_rdrf, 4'b0000, m_oe, m_fe};
  assign m_dat  = (addr == 2'b01) ? m_stat : rxq[nrd % 8];
  assign dbus   = (scisel && !rw) ? m_dat : 8'hzz;
  assign sciirq = m_rdrf;

  always @(posedge clk)
    if (scisel && !rw && addr == 2'b00) nrd <= nrd + 1;

  // Bus monitor
  typedef struct packed {logic w; logic [1:0] a; logic [7:0] d;} acc_t;
  acc_t log_q[$];
  logic prev_sel = 1'b0;
  int   b2b = 0, badtdr = 0, txr_err = 0;

  always @(negedge clk) begin
    if (scisel) begin
      if (prev_sel) b2b++;
      if (rw && addr == 2'b00 && !m_tdre) badtdr++;
      log_q.push_back('{rw, addr, dbus});
    end
    if (tx_ready !== (scisel && rw && addr == 2'b00)) txr_err++;
    prev_sel = scisel;
  end

  function automatic int n_acc0(int st, logic w);
    int n = 0;
    for (int i = st; i < log_q.size(); i++)
      if (log_q[i].a == 2'b00 && log_q[i].w == w) n++;
    return n;
  endfunction

  int pass = 0, total = 0;

  task automatic push_rx(input logic [7:0] b);
    rxq[npush % 8] = b;
    npush++;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({scisel, rw, addr, tx_ready, rx_valid, busy} !== 7'b0000001)
      $display("FAIL reset_outputs: got %b want 0000001", {scisel, rw, addr, tx_ready, rx_valid, busy});
    else pass++;
    total++;
    if ({rx_data, rx_oe, rx_fe} !== 10'd0) $display("FAIL reset_rx: got %h want 0", {rx_data, rx_oe, rx_fe});
    else pass++;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({scisel, rw, addr} !== 4'b1111 || dbus !== 8'h42 || busy !== 1'b1)
      $display("FAIL first_cfg: got sel/rw/addr=%b dbus=%h busy=%b want 1111 42 1", {scisel, rw, addr}, dbus, busy);
    else pass++;
    @(posedge clk); #1;
    total++;
    if (scisel !== 1'b0 || busy !== 1'b0) $display("FAIL cfg_turn: got sel=%b busy=%b want 0 0", scisel, busy);
    else pass++;
    @(posedge clk); #1;
    total++;
    if ({scisel, rw, addr} !== 4'b1001) $display("FAIL first_poll: got %b want 1001", {scisel, rw, addr});
    else pass++;
  endtask

  task automatic test_tx;
    int st = log_q.size();
    bit found = 0;
    #1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (n_acc0(st, 1'b1) !== 0) $display("FAIL tx_blocked: got %0d writes want 0", n_acc0(st, 1'b1));
    else pass++;
    #1 m_tdre = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_ready) begin found = 1; break; end
    end
    total++;
    if (!found || dbus !== 8'hA5) $display("FAIL tx_write: got found=%0d dbus=%h want 1 a5", found, dbus);
    else pass++;
    @(posedge clk); #2 tx_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (n_acc0(st, 1'b1) !== 1) $display("FAIL tx_count: got %0d writes want 1", n_acc0(st, 1'b1));
    else pass++;
  endtask

  task automatic test_rx;
    int st = log_q.size();
    bit found = 0;
    #1;
    rx_ready = 1'b1; m_fe = 1'b1; m_oe = 1'b0;
    push_rx(8'h3C);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_valid) begin found = 1; break; end
    end
    total++;
    if (!found || {rx_data, rx_oe, rx_fe} !== {8'h3C, 1'b0, 1'b1})
      $display("FAIL rx_byte: got v=%0d data=%h oe=%b fe=%b want 1 3c 0 1", found, rx_data, rx_oe, rx_fe);
    else pass++;
    @(posedge clk); #1;
    total++;
    if (rx_valid !== 1'b0) $display("FAIL rx_one_cycle: got rx_valid=%b want 0", rx_valid);
    else pass++;
    m_fe = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (n_acc0(st, 1'b0) !== 1) $display("FAIL rx_reads: got %0d want 1", n_acc0(st, 1'b0));
    else pass++;
  endtask

  task automatic test_rx_hold;
    int st = log_q.size();
    bit found = 0;
    #1;
    rx_ready = 1'b0;
    push_rx(8'h11);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_valid) begin found = 1; break; end
    end
    push_rx(8'h22);
    m_oe = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (!found || n_acc0(st, 1'b0) !== 1 || rx_valid !== 1'b1 || rx_data !== 8'h11)
      $display("FAIL rx_hold: got found=%0d reads=%0d v=%b data=%h want 1 1 1 11",
               found, n_acc0(st, 1'b0), rx_valid, rx_data);
    else pass++;
    #1 rx_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rx_valid !== 1'b0) $display("FAIL rx_release: got rx_valid=%b want 0", rx_valid);
    else pass++;
    #1 rx_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_valid) begin found = 1; break; end
    end
    total++;
    if (!found || rx_data !== 8'h22 || rx_oe !== 1'b1 || n_acc0(st, 1'b0) !== 2)
      $display("FAIL rx_second: got v=%0d data=%h oe=%b reads=%0d want 1 22 1 2",
               found, rx_data, rx_oe, n_acc0(st, 1'b0));
    else pass++;
    #1 m_oe = 1'b0; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int st = log_q.size();
    int k = 0;
    bit found = 0;
    acc_t a0[2];
    a0[0] = '0; a0[1] = '0;
    #2;
    m_tdre = 1'b1; rx_ready = 1'b1;
    tx_data = 8'h77; tx_valid = 1'b1;
    push_rx(8'h99);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_ready) begin found = 1; break; end
    end
    @(posedge clk); #2 tx_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = st; i < log_q.size(); i++)
      if (log_q[i].a == 2'b00 && k < 2) begin a0[k] = log_q[i]; k++; end
    total++;
    if (!found || k !== 2 || a0[0] !== acc_t'({1'b0, 2'b00, 8'h99}) || a0[1] !== acc_t'({1'b1, 2'b00, 8'h77}))
      $display("FAIL rx_before_tx: got k=%0d first=%h second=%h want 2 099 477", k, a0[0], a0[1]);
    else pass++;
  endtask

  task automatic test_cfg_load;
    bit found = 0;
    #1;
    cfg_baudsel = 2'b01; cfg_tie = 1'b0; cfg_rie = 1'b0;
    tx_data = 8'h12; tx_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_ready) begin found = 1; break; end
    end
    cfg_load = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!found || busy !== 1'b1 || scisel !== 1'b0)
      $display("FAIL cfg_busy: got found=%0d busy=%b sel=%b want 1 1 0", found, busy, scisel);
    else pass++;
    #1 cfg_load = 1'b0; tx_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({scisel, rw, addr} !== 4'b1111 || dbus !== 8'h01)
      $display("FAIL cfg_rewrite: got sel/rw/addr=%b dbus=%h want 1111 01", {scisel, rw, addr}, dbus);
    else pass++;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) $display("FAIL cfg_busy_fall: got %b want 0", busy);
    else pass++;
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    #1;
    rx_ready = 1'b0;
    push_rx(8'hE1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scisel && !rw && addr == 2'b00) begin found = 1; break; end
    end
    rst = 1'b1;
    #1;
    total++;
    if (!found || scisel !== 1'b0 || rw !== 1'b0 || rx_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL reset_mid: got found=%0d sel=%b rw=%b rxv=%b busy=%b want 1 0 0 0 1",
               found, scisel, rw, rx_valid, busy);
    else pass++;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({scisel, rw, addr} !== 4'b1111 || dbus !== 8'h01)
      $display("FAIL reset_mid_cfg: got %b dbus=%h want 1111 01", {scisel, rw, addr}, dbus);
    else pass++;
    #1 rx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (nrd !== npush) $display("FAIL reset_mid_drain: got reads=%0d want %0d", nrd, npush);
    else pass++;
  endtask

  task automatic test_protocol;
    total++;
    if (b2b !== 0) $display("FAIL back_to_back_sel: got %0d want 0", b2b);
    else pass++;
    total++;
    if (badtdr !== 0) $display("FAIL tdr_without_tdre: got %0d want 0", badtdr);
    else pass++;
    total++;
    if (txr_err !== 0) $display("FAIL tx_ready_decode: got %0d want 0", txr_err);
    else pass++;
  endtask

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_rx_hold;
    test_back_to_back;
    test_cfg_load;
    test_reset_mid;
    test_protocol;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
